// File: rtl/demux_pkg.sv
// Shared constants and state encoding for the serial-to-lane sequencer.
package demux_pkg;
  localparam int LANES     = 8;
  localparam int SEL_W     = 3;
  localparam int LAST_LANE = LANES - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;
endpackage

// File: rtl/demux_lane_seq_if.sv
// Serial input, lane output and frame handshake bundle of the sequencer.
interface demux_lane_seq_if #(
   parameter int LANES = demux_pkg::LANES,
   parameter int SEL_W = demux_pkg::SEL_W
);
   logic             start;
   logic             abort;
   logic             din_valid;
   logic             din;
   logic             din_ready;
   logic [SEL_W-1:0] sel;
   logic             lane_din;
   logic             lane_stb;
   logic [LANES-1:0] frame_data;
   logic             frame_valid;
   logic             frame_ack;

   modport master (
      output start, abort, din_valid, din, frame_ack,
      input  din_ready, sel, lane_din, lane_stb, frame_data, frame_valid
   );

   modport slave (
      input  start, abort, din_valid, din, frame_ack,
      output din_ready, sel, lane_din, lane_stb, frame_data, frame_valid
   );
endinterface

// File: rtl/demux_lane_seq_lane_counter.sv
// Lane index counter: clear has priority, wrap flags the increment out of the last lane.
module lane_counter #(
   parameter int W    = demux_pkg::SEL_W,
   parameter int LAST = demux_pkg::LAST_LANE
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o,
   output logic         wrap_o
);
   logic [W-1:0] cnt_q, cnt_d;

   assign wrap_o = inc_i && (cnt_q == W'(LAST));
   assign cnt_o  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)       cnt_d = '0;
      else if (wrap_o) cnt_d = '0;
      else if (inc_i)  cnt_d = cnt_q + W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/demux_lane_seq.sv
// Serial-to-lane sequencer: steers accepted bits to lanes 0..7 and holds the
// assembled byte until the consumer acknowledges it.
module demux_lane_seq #(
   parameter int LANES = demux_pkg::LANES,
   parameter int SEL_W = demux_pkg::SEL_W
) (
   input logic            clk,
   input logic            rst,
   demux_lane_seq_if.slave bus
);
   import demux_pkg::*;

   state_e           state_q;
   logic [SEL_W-1:0] sel_q;
   logic             lane_din_q;
   logic             lane_stb_q;
   logic [LANES-1:0] frame_data_q;
   logic             frame_valid_q;

   logic [SEL_W-1:0] cnt;
   logic             wrap;
   logic             in_run;
   logic             accept;
   logic             cnt_clr;

   assign in_run  = (state_q == ST_RUN);
   // abort wins over a bit offered in the same cycle
   assign accept  = in_run && bus.din_valid && !bus.abort;
   assign cnt_clr = ((state_q == ST_IDLE) && bus.start) ||
                    (bus.abort && (state_q != ST_IDLE));

   lane_counter #(.W(SEL_W), .LAST(LANES - 1)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (cnt_clr),
      .inc_i  (accept),
      .cnt_o  (cnt),
      .wrap_o (wrap)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         sel_q         <= '0;
         lane_din_q    <= 1'b0;
         lane_stb_q    <= 1'b0;
         frame_data_q  <= '0;
         frame_valid_q <= 1'b0;
      end else begin
         lane_stb_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.start) state_q <= ST_RUN;
            end
            ST_RUN: begin
               if (bus.abort) begin
                  state_q <= ST_IDLE;
               end else if (accept) begin
                  sel_q             <= cnt;
                  lane_din_q        <= bus.din;
                  lane_stb_q        <= 1'b1;
                  frame_data_q[cnt] <= bus.din;
                  if (wrap) begin
                     state_q       <= ST_HOLD;
                     frame_valid_q <= 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (bus.abort || bus.frame_ack) begin
                  state_q       <= ST_IDLE;
                  frame_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q       <= ST_IDLE;
               frame_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.din_ready   = in_run;
   assign bus.sel         = sel_q;
   assign bus.lane_din    = lane_din_q;
   assign bus.lane_stb    = lane_stb_q;
   assign bus.frame_data  = frame_data_q;
   assign bus.frame_valid = frame_valid_q;
endmodule

// File: tb/tb_demux_lane_seq.sv
// Bench for demux_lane_seq: vector table, directed corner sequences and a
// randomized run against a bit-count reference model.
module tb_demux_lane_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   demux_lane_seq_if bus ();

   demux_lane_seq dut (.clk(clk), .rst(rst), .bus(bus));

   int n_tests = 0;
   int n_fail  = 0;

   // Reference: a frame is "open" once started; n counts accepted bits (8 = held)
   bit       m_open;
   int       m_n;
   bit [2:0] m_sel;
   bit       m_ld;
   bit       m_stb;
   bit [7:0] m_fd;
   int       stb_seen;
   int       fv_seen;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_open = 0; m_n = 0; m_sel = 0; m_ld = 0; m_stb = 0; m_fd = 0;
   endtask

   task automatic model_step();
      m_stb = 0;
      if (!m_open) begin
         if (bus.start) begin m_open = 1; m_n = 0; end
      end else if (bus.abort) begin
         m_open = 0;
      end else if (m_n < 8) begin
         if (bus.din_valid) begin
            m_sel = 3'(m_n);
            m_ld  = bus.din;
            m_stb = 1;
            m_fd[m_n] = bus.din;
            m_n++;
         end
      end else if (bus.frame_ack) begin
         m_open = 0;
      end
   endtask

   task automatic check_model();
      chk("sel",         32'(bus.sel),         32'(m_sel));
      chk("lane_din",    32'(bus.lane_din),    32'(m_ld));
      chk("lane_stb",    32'(bus.lane_stb),    32'(m_stb));
      chk("frame_data",  32'(bus.frame_data),  32'(m_fd));
      chk("frame_valid", 32'(bus.frame_valid), 32'(m_open && m_n == 8));
      chk("din_ready",   32'(bus.din_ready),   32'(m_open && m_n < 8));
   endtask

   task automatic drive(input bit s, input bit a, input bit v, input bit d, input bit k);
      bus.start = s; bus.abort = a; bus.din_valid = v; bus.din = d; bus.frame_ack = k;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      if (bus.lane_stb === 1'b1) stb_seen++;
      if (bus.frame_valid === 1'b1) fv_seen++;
      check_model();
   endtask

   typedef struct {
      bit       start, dv, din, ack;
      bit [2:0] sel;
      bit       stb, rdy, fv;
      bit [7:0] fd;
   } vec_t;
   vec_t tbl [11];

   initial begin
      logic [7:0] pat;
      logic [7:0] held;
      pat = 8'h4D;
      drive(0, 0, 0, 0, 0);
      model_reset();

      #12;
      chk("rst_sel",   32'(bus.sel), 0);
      chk("rst_stb",   32'(bus.lane_stb), 0);
      chk("rst_ld",    32'(bus.lane_din), 0);
      chk("rst_fd",    32'(bus.frame_data), 0);
      chk("rst_fv",    32'(bus.frame_valid), 0);
      chk("rst_ready", 32'(bus.din_ready), 0);
      @(negedge clk); rst = 0;

      // back-to-back frame with ack tied high
      tbl[0] = '{1, 0, 0, 1, 3'd0, 0, 1, 0, 8'h00};
      for (int k = 1; k <= 8; k++)
         tbl[k] = '{0, 1, pat[k-1], 1, 3'(k-1), 1, (k < 8), (k == 8),
                    8'(pat & 8'((1 << k) - 1))};
      tbl[9]  = '{0, 0, 0, 1, 3'd7, 0, 0, 0, 8'h4D};
      tbl[10] = '{1, 0, 0, 0, 3'd7, 0, 1, 0, 8'h4D};
      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].start, 0, tbl[i].dv, tbl[i].din, tbl[i].ack);
         cycle();
         chk($sformatf("tbl%0d_sel", i),   32'(bus.sel),         32'(tbl[i].sel));
         chk($sformatf("tbl%0d_stb", i),   32'(bus.lane_stb),    32'(tbl[i].stb));
         chk($sformatf("tbl%0d_ready", i), 32'(bus.din_ready),   32'(tbl[i].rdy));
         chk($sformatf("tbl%0d_fv", i),    32'(bus.frame_valid), 32'(tbl[i].fv));
         chk($sformatf("tbl%0d_fd", i),    32'(bus.frame_data),  32'(tbl[i].fd));
      end
      drive(0, 1, 0, 0, 0); cycle();
      chk("abort_idle_ready", 32'(bus.din_ready), 0);

      // stalled stream, then hold with ack low while din_valid/start are offered
      drive(1, 0, 0, 0, 0); cycle();
      stb_seen = 0;
      for (int k = 0; k < 8; k++) begin
         drive(0, 0, 1, pat[k], 0); cycle();
         chk("stall_sel", 32'(bus.sel), 32'(k));
         drive(0, 0, 0, 0, 0); cycle();
      end
      chk("stall_stb_count", 32'(stb_seen), 8);
      chk("stall_fd", 32'(bus.frame_data), 32'h4D);
      chk("stall_fv", 32'(bus.frame_valid), 1);
      held = bus.frame_data;
      stb_seen = 0;
      for (int k = 0; k < 5; k++) begin
         drive((k == 2), 0, 1, k[0], 0); cycle();
         chk("hold_fd", 32'(bus.frame_data), 32'(held));
         chk("hold_fv", 32'(bus.frame_valid), 1);
      end
      chk("hold_no_stb", 32'(stb_seen), 0);
      drive(0, 0, 0, 0, 1); cycle();
      chk("hold_ack_fv", 32'(bus.frame_valid), 0);
      chk("hold_ack_ready", 32'(bus.din_ready), 0);

      // abort together with the 5th accept
      drive(1, 0, 0, 0, 0); cycle();
      for (int k = 0; k < 4; k++) begin drive(0, 0, 1, 1, 1); cycle(); end
      fv_seen = 0;
      drive(0, 1, 1, 0, 1); cycle();
      chk("abort_no_stb", 32'(bus.lane_stb), 0);
      chk("abort_ready", 32'(bus.din_ready), 0);
      chk("abort_sel_kept", 32'(bus.sel), 3);
      drive(0, 0, 1, 1, 1);
      for (int k = 0; k < 3; k++) cycle();
      chk("abort_fv_never", 32'(fv_seen), 0);
      drive(1, 0, 0, 0, 0); cycle();
      drive(0, 0, 1, 1, 0); cycle();
      chk("abort_restart_sel", 32'(bus.sel), 0);
      chk("abort_restart_stb", 32'(bus.lane_stb), 1);

      // start ignored in RUN
      drive(0, 1, 0, 0, 0); cycle();
      drive(1, 0, 0, 0, 0); cycle();
      drive(0, 0, 1, 0, 0); cycle(); cycle();
      drive(1, 0, 0, 0, 0); cycle();
      chk("run_start_ready", 32'(bus.din_ready), 1);
      for (int k = 0; k < 6; k++) begin
         drive(0, 0, 1, 1, 0); cycle();
         chk("run_start_sel", 32'(bus.sel), 32'(k + 2));
      end
      chk("run_start_fv", 32'(bus.frame_valid), 1);
      chk("run_start_fd", 32'(bus.frame_data), 32'hFC);
      drive(0, 0, 0, 0, 1); cycle();

      // async reset mid-RUN after 3 accepts
      drive(1, 0, 0, 0, 0); cycle();
      for (int k = 0; k < 3; k++) begin drive(0, 0, 1, 1, 0); cycle(); end
      drive(0, 0, 0, 0, 0);
      #2 rst = 1;
      #1;
      chk("arst_sel",   32'(bus.sel), 0);
      chk("arst_stb",   32'(bus.lane_stb), 0);
      chk("arst_ld",    32'(bus.lane_din), 0);
      chk("arst_fd",    32'(bus.frame_data), 0);
      chk("arst_fv",    32'(bus.frame_valid), 0);
      chk("arst_ready", 32'(bus.din_ready), 0);
      model_reset();
      @(posedge clk); @(negedge clk); rst = 0;
      cycle();
      chk("arst_idle", 32'(bus.din_ready), 0);
      drive(1, 0, 0, 0, 0); cycle();
      for (int k = 0; k < 8; k++) begin drive(0, 0, 1, pat[k], 0); cycle(); end
      chk("arst_frame_fd", 32'(bus.frame_data), 32'h4D);
      chk("arst_frame_fv", 32'(bus.frame_valid), 1);
      drive(0, 0, 0, 0, 1); cycle();

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(5) == 0), ($urandom_range(19) == 0),
               ($urandom_range(2) != 0), 1'($urandom), ($urandom_range(3) == 0));
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/demux_lane_seq.md
# demux_lane_seq

Serial-to-lane sequencer feeding the 1-to-8 lane demultiplexer. It accepts a framed serial bit stream, steers each accepted bit to lanes 0..7 in order by driving a registered lane select, strobe and data bit, and assembles the eight bits into a parallel byte. The completed frame is held until the consumer acknowledges it. The block sits directly upstream of the demux and owns all lane sequencing.

## Interface
Parameters:
- LANES, 8, number of output lanes (fixed at 8 in this revision)
- SEL_W, 3, lane select width, equal to log2(LANES)

Ports:
- clk  input  1  single system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse that begins a frame; honoured only in IDLE
- abort  input  1  drops the current frame and returns to IDLE
- din_valid  input  1  serial bit qualifier
- din  input  1  serial data bit
- din_ready  output  1  high while in RUN; a bit is accepted when din_valid && din_ready
- sel  output  SEL_W  registered lane select to the demux
- lane_din  output  1  registered bit to the demux
- lane_stb  output  1  one-cycle strobe marking sel/lane_din valid
- frame_data  output  LANES  assembled byte; bit i = bit steered to lane i
- frame_valid  output  1  high in HOLD
- frame_ack  input  1  consumer acknowledge; completes the frame

## Operation
- States: IDLE, RUN, HOLD. Reset state is IDLE.
- Reset values: sel=0, lane_din=0, lane_stb=0, frame_data=8'h00, frame_valid=0, din_ready=0. The internal lane counter resets to 0.
- IDLE -> RUN on start. The lane counter clears to 0. frame_data is left unchanged until the first accept.
- In RUN, each accept does the following:
  - sel<=cnt, lane_din<=din, lane_stb<=1.
  - frame_data[cnt]<=din.
  - cnt<=cnt+1, modulo 8.
  - Cycles without an accept drive lane_stb=0, and sel/lane_din hold their values.
- When the accept occurs with cnt==7, the block goes RUN -> HOLD, and cnt wraps to 0.
- In HOLD, frame_valid=1 and frame_data is stable. din_valid is ignored and start is ignored.
- HOLD -> IDLE on frame_ack. frame_valid drops the next cycle.
- frame_ack outside HOLD is ignored.
- abort in RUN or HOLD:
  - next state is IDLE, cnt=0, frame_valid=0;
  - a bit presented in the same cycle is not accepted;
  - abort has priority over accept, start and frame_ack.
- start while in RUN or HOLD is ignored, and does not restart the count.
- frame_data keeps its last value after HOLD->IDLE and after abort. The consumer must only sample it while frame_valid=1.

## Timing
- din_ready is combinational from state: it is 1 in the same cycle the FSM is in RUN, i.e. from the cycle after start.
- Lane output latency is one cycle: an accept at edge N gives sel/lane_din/lane_stb valid after edge N and for one cycle.
- frame_valid rises in the cycle after the 8th accept. That is the same cycle as the lane_stb for lane 7.
- Minimum frame length:
  - 1 start cycle, then 8 accept cycles, then 1 HOLD cycle when frame_ack is already high. That is 10 cycles from the start edge back to IDLE.
  - A new start is honoured in the cycle after returning to IDLE.
- rst asserted mid-frame clears all outputs immediately, without waiting for a clock edge. Operation resumes in IDLE after deassertion.
- Gaps in din_valid stall the counter with no loss of state. There is no timeout.

## Structure
- A shared package demux_pkg holds:
  - LANES and SEL_W;
  - the state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_HOLD=2'd2;
  - the value LAST_LANE = LANES-1.
- One natural sub-module is lane_counter: a SEL_W-bit counter with clr, inc and a wrap flag (asserted when count==LAST_LANE and inc is high), using async active-high reset.
- The FSM, the output registers and the frame_data register all live in the top level.

## Test plan
- Reset check: assert rst mid-RUN after 3 accepts -> all outputs are 0 immediately. After release, state is IDLE, and start followed by 8 bits works normally.
- Back-to-back frame: start, then bits 1,0,1,1,0,0,1,0 on consecutive cycles ->
  - lane_stb high on 8 cycles with sel 0..7;
  - frame_data=8'h4D with frame_valid high;
  - with frame_ack tied high, back in IDLE 10 cycles after start.
- Stalled stream: same bits with din_valid low every other cycle -> same frame_data=8'h4D, and sel advances only on accepts.
- Hold and ignore: frame complete, frame_ack low for 5 cycles, with din_valid=1 and start pulsed ->
  - frame_data stays stable;
  - no lane_stb;
  - no restart;
  - frame_ack then gives IDLE.
- Abort: abort on the same cycle as the 5th accept -> no lane_stb for that bit, frame_valid never rises, state is IDLE, and the next frame starts at sel=0.
- Start ignored in RUN: a start pulse after 2 accepts -> the count continues at lane 2 and the frame completes after 6 more bits.
